// File: rtl/traffic_pkg.sv
// traffic_pkg: shared lamp pattern layout, monitor states and fault codes
package traffic_pkg;
    typedef enum logic [1:0] {
        ST_MONITOR = 2'd0,
        ST_FAULT   = 2'd1,
        ST_RECOVER = 2'd2
    } mon_state_t;

    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_CONFLICT     = 3'd1;
    localparam logic [2:0] FC_MALFORMED    = 3'd2;
    localparam logic [2:0] FC_SKIP_YELLOW  = 3'd3;
    localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;
    localparam logic [2:0] FC_BAD_GREEN    = 3'd5;

    // Lamp pattern ordering {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
    localparam int LP_NS_R = 5;
    localparam int LP_NS_Y = 4;
    localparam int LP_NS_G = 3;
    localparam int LP_EW_R = 2;
    localparam int LP_EW_Y = 1;
    localparam int LP_EW_G = 0;

    localparam logic [5:0] PAT_ALL_RED = 6'b100_100;

    // A direction is well formed when exactly one of its three lamps is lit
    function automatic logic one_lit(input logic [2:0] d);
        return (d == 3'b001) || (d == 3'b010) || (d == 3'b100);
    endfunction
endpackage

// File: rtl/lamp_flash_gen.sv
// lamp_flash_gen: half-period counter and phase toggle for the fault flash
module lamp_flash_gen #(
    parameter int HALF_TICKS = 1,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_phase
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_wrap;

    assign w_wrap  = r_cnt == CNT_W'(HALF_TICKS - 1);
    assign o_phase = r_phase;

    // Restart lights the lamps; while enabled, flip the phase every HALF_TICKS cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (i_restart) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (i_enable) begin
            r_cnt   <= w_wrap ? '0 : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
            r_phase <= r_phase ^ w_wrap;
        end
    end
endmodule

// File: rtl/lamp_conflict_monitor.sv
// lamp_conflict_monitor: registers lamp commands and blocks illegal patterns/sequences
module lamp_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW_TICKS = 5,
    parameter int MIN_ALLRED_TICKS = 2,
    parameter int FLASH_HALF_TICKS = 1,
    parameter int CNT_W            = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_red_i,
    input  logic       ns_yellow_i,
    input  logic       ns_green_i,
    input  logic       ew_red_i,
    input  logic       ew_yellow_i,
    input  logic       ew_green_i,
    input  logic       fault_clear,
    output logic       ns_red_o,
    output logic       ns_yellow_o,
    output logic       ns_green_o,
    output logic       ew_red_o,
    output logic       ew_yellow_o,
    output logic       ew_green_o,
    output logic       fault,
    output logic [2:0] fault_code
);
    mon_state_t       r_state, w_next;
    logic [2:0]       r_code, w_next_code, w_code;
    logic [5:0]       w_cur, r_prev, r_lamps, w_out;
    logic [CNT_W-1:0] r_phase_cnt;
    logic [CNT_W:0]   w_held;
    logic             w_conflict, w_malformed, w_skip, w_short_y, w_bad_g, w_viol;
    logic             w_flash;

    assign w_cur  = {ns_red_i, ns_yellow_i, ns_green_i, ew_red_i, ew_yellow_i, ew_green_i};
    assign w_held = {1'b0, r_phase_cnt} + (CNT_W+1)'(1);

    assign w_conflict  = (w_cur[LP_NS_Y] | w_cur[LP_NS_G]) & (w_cur[LP_EW_Y] | w_cur[LP_EW_G]);
    assign w_malformed = !one_lit(w_cur[LP_NS_R:LP_NS_G]) || !one_lit(w_cur[LP_EW_R:LP_EW_G]);
    assign w_skip      = (r_prev[LP_NS_G] & w_cur[LP_NS_R]) | (r_prev[LP_EW_G] & w_cur[LP_EW_R]);
    assign w_short_y   = ((r_prev[LP_NS_Y] & ~w_cur[LP_NS_Y]) | (r_prev[LP_EW_Y] & ~w_cur[LP_EW_Y]))
                       & (w_held < (CNT_W+1)'(MIN_YELLOW_TICKS));
    assign w_bad_g     = ((~r_prev[LP_NS_G] & w_cur[LP_NS_G]) | (~r_prev[LP_EW_G] & w_cur[LP_EW_G]))
                       & ((r_prev != PAT_ALL_RED) | (w_held < (CNT_W+1)'(MIN_ALLRED_TICKS)));

    assign w_code = w_conflict  ? FC_CONFLICT     :
                    w_malformed ? FC_MALFORMED    :
                    w_skip      ? FC_SKIP_YELLOW  :
                    w_short_y   ? FC_SHORT_YELLOW :
                    w_bad_g     ? FC_BAD_GREEN    : FC_NONE;
    assign w_viol = w_code != FC_NONE;

    // Next-state and fault code: first code sticks in FAULT, RECOVER takes a fresh one
    always_comb begin
        w_next      = r_state;
        w_next_code = r_code;
        case (r_state)
            ST_MONITOR: begin
                w_next      = w_viol ? ST_FAULT : ST_MONITOR;
                w_next_code = w_viol ? w_code : r_code;
            end
            ST_FAULT: w_next = (fault_clear && !w_viol) ? ST_RECOVER : ST_FAULT;
            ST_RECOVER: begin
                w_next      = w_viol ? ST_FAULT : ((w_cur == PAT_ALL_RED) ? ST_MONITOR : ST_RECOVER);
                w_next_code = w_viol ? w_code : ((w_cur == PAT_ALL_RED) ? FC_NONE : r_code);
            end
            default: begin
                w_next      = ST_FAULT;
                w_next_code = FC_MALFORMED;
            end
        endcase
    end

    // State and fault code registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_MONITOR;
            r_code  <= FC_NONE;
        end else begin
            r_state <= w_next;
            r_code  <= w_next_code;
        end
    end

    // Pattern history runs in every state so sequencing checks stay valid after recovery
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev      <= PAT_ALL_RED;
            r_phase_cnt <= CNT_W'(MIN_ALLRED_TICKS - 1);
        end else begin
            r_prev      <= w_cur;
            r_phase_cnt <= (w_cur != r_prev) ? '0 : ((&r_phase_cnt) ? r_phase_cnt : r_phase_cnt + 1'b1);
        end
    end

    // Only a clean pattern seen in MONITOR reaches the drivers; everything else parks at all-red
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_lamps <= PAT_ALL_RED;
        else       r_lamps <= (r_state == ST_MONITOR && !w_viol) ? w_cur : PAT_ALL_RED;
    end

    lamp_flash_gen #(
        .HALF_TICKS (FLASH_HALF_TICKS),
        .CNT_W      (CNT_W)
    ) u_flash (
        .clk       (clk),
        .reset     (reset),
        .i_enable  (r_state == ST_FAULT),
        .i_restart ((w_next == ST_FAULT) && (r_state != ST_FAULT)),
        .o_phase   (w_flash)
    );

    assign w_out = (r_state == ST_FAULT) ? {w_flash, 2'b00, w_flash, 2'b00} : r_lamps;
    assign {ns_red_o, ns_yellow_o, ns_green_o, ew_red_o, ew_yellow_o, ew_green_o} = w_out;
    assign fault      = r_state != ST_MONITOR;
    assign fault_code = r_code;
endmodule
